instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder: packs decoded fields (kind, register indices, funct3/funct7, 32-bit immediate) into a 32-bit instruction word.
- Used by the boot/test program loader and the self-check bench to generate instruction-memory images. Its output is what the CPU decoder later consumes.
- Registered output stage with valid/ready handshake, immediate range checking and an auto-incrementing word write address.

Parameters:
- ADDR_W, 10, width of instruction-memory word address.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- clear  input  1  synchronous; loads addr counter with start_addr, clears err_sticky and count
- start_addr  input  ADDR_W  address loaded on clear
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder can accept
- in_kind  input  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 ALUI, 8 ALUR, 9-15 invalid
- in_rd / in_rs1 / in_rs2  input  5 each  register indices
- in_funct3  input  3
- in_funct7  input  7  used for ALUR, and for ALUI when funct3 is 001 or 101 (placed in bits 31:25)
- in_imm  input  32  signed byte offset / value
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts
- out_instr  output  32  encoded word
- out_addr  output  ADDR_W  word address for out_instr
- out_err  output  1  this word had an invalid kind or out-of-range imm
- err_sticky  output  1  OR of all out_err since reset/clear
- count  output  16  number of words handed off (saturates at 0xFFFF)

Behaviour:
- Reset (async, rst=1) values:
  - out_valid=0, out_instr=0, out_addr=0, out_err=0.
  - err_sticky=0, count=0, internal addr counter=0.
  - in_ready=1 as soon as rst deasserts.
- Handshake:
  - in_ready = !out_valid | out_ready (1-entry pipeline, combinational ready).
  - Input accepted on in_valid & in_ready. Encoded word is registered on the next clk edge, so latency is 1 cycle.
  - out_* fields are held stable while out_valid & !out_ready.
  - Back-to-back throughput is 1 word/cycle when out_ready=1.
- Addressing:
  - Output handshake (out_valid & out_ready) increments the internal addr and count.
  - out_addr is the addr captured when the word was loaded into the output register.
  - addr wraps modulo 2^ADDR_W. count saturates.
- clear:
  - Has priority over a same-cycle handshake for addr, count and err_sticky: addr=start_addr, count=0, err_sticky=0.
  - out_valid is dropped, so a pending word is discarded.
  - An input accepted in the same cycle is discarded.
- Encoding:
  - opcode[6:0] per kind: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011.
  - rd in [11:7], funct3 in [14:12], rs1 in [19:15], rs2 in [24:20], funct7 in [31:25].
  - I (JALR, LOAD, ALUI): imm[11:0] in [31:20].
  - ALUI shifts (funct3 001/101): [31:25]=funct7, [24:20]=imm[4:0].
  - S: imm[11:5] in [31:25], imm[4:0] in [11:7].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: imm[31:12] in [31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - Fields not used by a format are zero.
- Range checks (out_err=1 when violated; the word is still encoded from truncated bits):
  - I/S: -2048..2047.
  - Shift: imm 0..31.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
- Invalid kind: out_instr=0x00000000, out_err=1.
- err_sticky sets on the output handshake of a word with out_err=1.
- rst mid-stream drops any pending word immediately; no partial output.

Test Plan:
- ALUI rd=1 rs1=0 f3=0 imm=5 -> out_instr 0x00500093, out_err=0, out_addr=0; after handshake count=1.
- LUI rd=2 imm=0x12345000, then BRANCH f3=0 rs1=1 rs2=2 imm=-8, with out_ready=1 both cycles -> 0x12345137 @addr0, then 0xFE208CE3 @addr1, one word per cycle.
- STORE f3=2 rs1=2 rs2=5 imm=12 with out_ready=0 for 3 cycles -> out_instr holds 0x00512623, in_ready=0, addr unchanged; releasing out_ready gives a single handshake and count increments by 1.
- ALUI imm=4096, then kind=12 -> both words have out_err=1; the second has out_instr=0; err_sticky=1 after the first handshake.
- clear with start_addr=0x3F0 while a word is pending -> pending word dropped, err_sticky=0, count=0. Next word emitted at out_addr=0x3F0; with ADDR_W=10, addr wraps 0x3FF -> 0x000.
- rst asserted asynchronously mid-cycle with out_valid=1 -> out_valid=0 and out_addr=0 without waiting for a clk edge.

Source files
------------

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Streaming RV32I instruction encoder. Decoded fields (kind, register indices,
// funct3/funct7, 32-bit immediate) are packed into a 32-bit instruction word
// and presented through a one-entry registered output stage with a
// valid/ready handshake. Each word carries the instruction-memory word
// address it belongs to. An error flag marks words whose kind is invalid or
// whose immediate does not fit the instruction format.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   clear          sync: addr <= start_addr, count/err_sticky <= 0, drop word
//   start_addr     address loaded by clear
//   in_valid/in_ready, in_kind, in_rd, in_rs1, in_rs2, in_funct3,
//   in_funct7, in_imm            input field stream
//   out_valid/out_ready, out_instr, out_addr, out_err   encoded word stream
//   err_sticky     OR of out_err over all handed-off words since reset/clear
//   count          number of handed-off words, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky,
    output logic [15:0]       count
);

    localparam logic [3:0] K_LUI    = 4'd0;
    localparam logic [3:0] K_AUIPC  = 4'd1;
    localparam logic [3:0] K_JAL    = 4'd2;
    localparam logic [3:0] K_JALR   = 4'd3;
    localparam logic [3:0] K_BRANCH = 4'd4;
    localparam logic [3:0] K_LOAD   = 4'd5;
    localparam logic [3:0] K_STORE  = 4'd6;
    localparam logic [3:0] K_ALUI   = 4'd7;
    localparam logic [3:0] K_ALUR   = 4'd8;

    // 12-bit signed immediate range shared by I and S formats
    function automatic logic imm12_bad(input logic signed [31:0] imm);
        return (imm < -32'sd2048) || (imm > 32'sd2047);
    endfunction

    // Saturating word counter increment
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Returns {err, instr}. The word is always built from the truncated
    // immediate bits; err only flags that the value did not fit.
    function automatic logic [32:0] encode(
        input logic [3:0]         kind,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic signed [31:0] imm
    );
        logic [31:0] w;
        logic        err;
        logic        is_shift;
        w        = 32'd0;
        err      = 1'b0;
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);
        case (kind)
            K_LUI: begin
                w   = {imm[31:12], rd, 7'b0110111};
                err = (imm[11:0] != 12'd0);
            end
            K_AUIPC: begin
                w   = {imm[31:12], rd, 7'b0010111};
                err = (imm[11:0] != 12'd0);
            end
            K_JAL: begin
                w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                err = (imm < -32'sd1048576) || (imm > 32'sd1048574) || imm[0];
            end
            K_JALR: begin
                w   = {imm[11:0], rs1, f3, rd, 7'b1100111};
                err = imm12_bad(imm);
            end
            K_BRANCH: begin
                w   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
                err = (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
            end
            K_LOAD: begin
                w   = {imm[11:0], rs1, f3, rd, 7'b0000011};
                err = imm12_bad(imm);
            end
            K_STORE: begin
                w   = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
                err = imm12_bad(imm);
            end
            K_ALUI: begin
                if (is_shift) begin
                    // shamt lives in the rs2 slot, funct7 selects SRLI/SRAI
                    w   = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
                    err = (imm < 32'sd0) || (imm > 32'sd31);
                end else begin
                    w   = {imm[11:0], rs1, f3, rd, 7'b0010011};
                    err = imm12_bad(imm);
                end
            end
            K_ALUR: begin
                w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            default: begin
                w   = 32'd0;
                err = 1'b1;
            end
        endcase
        return {err, w};
    endfunction

    logic              vld_p0;
    logic [31:0]       instr_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              err_p0;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              handoff;
    logic [ADDR_W-1:0] addr_inc;
    logic [32:0]       enc;

    assign in_ready = !vld_p0 || out_ready;
    assign accept   = in_valid && in_ready;
    assign handoff  = vld_p0 && out_ready;
    assign addr_inc = addr_q + ADDR_W'(1);
    assign enc      = encode(in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

    // Stage p0: encoded word register plus address/count bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0     <= 1'b0;
            instr_p0   <= 32'd0;
            addr_p0    <= '0;
            err_p0     <= 1'b0;
            addr_q     <= '0;
            count      <= 16'd0;
            err_sticky <= 1'b0;
        end else if (clear) begin
            vld_p0     <= 1'b0;
            addr_q     <= start_addr;
            count      <= 16'd0;
            err_sticky <= 1'b0;
        end else begin
            if (handoff) begin
                addr_q <= addr_inc;
                count  <= sat_inc(count);
                if (err_p0) begin
                    err_sticky <= 1'b1;
                end
            end
            if (accept) begin
                vld_p0   <= 1'b1;
                instr_p0 <= enc[31:0];
                err_p0   <= enc[32];
                // A word loaded while the previous one hands off belongs
                // to the next address.
                addr_p0  <= handoff ? addr_inc : addr_q;
            end else if (handoff) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p0;
    assign out_instr = instr_p0;
    assign out_addr  = addr_p0;
    assign out_err   = err_p0;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  addr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [9:0]  start_addr = 10'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_kind = 4'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [6:0]  in_funct7 = 7'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        out_err;
    logic        err_sticky;
    logic [15:0] count;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    instr_encoder #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handoff pops one expected word and compares it
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got 0x%0h @0x%0h, expected no word", out_instr, out_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_addr", 32'(out_addr), 32'(e.addr));
                chk("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one field set until accepted; push the expectation if requested.
    task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] ei, input logic [9:0] ea,
                        input logic ee, input bit push, output int waits);
        bit acc;
        in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid = 1'b1;
        waits = 0;
        do begin
            acc = in_ready;
            if (acc && push) exp_q.push_back('{ei, ea, ee});
            @(posedge clk);
            #1;
            waits++;
        end while (!acc && waits < 50);
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no accept after %0d cycles, expected accept", waits);
        end
    endtask

    initial begin
        int w;
        int w2;
        int guard;

        // Reset state
        idle(2);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        idle(1);

        // addi x1, x0, 5
        out_ready = 1'b1;
        send(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 10'd0, 1'b0, 1'b1, w);
        idle(2);
        chk("count_after_first", 32'(count), 32'd1);

        clear = 1'b1; start_addr = 10'd0;
        idle(1);
        clear = 1'b0;
        chk("count_after_clear0", 32'(count), 32'd0);

        // Back-to-back LUI then BRANCH
        send(4'd0, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h12345137, 10'd0, 1'b0, 1'b1, w);
        send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8, 32'hFE208CE3, 10'd1, 1'b0, 1'b1, w2);
        chk("b2b_wait_lui", 32'(w), 32'd1);
        chk("b2b_wait_branch", 32'(w2), 32'd1);
        idle(2);
        chk("count_after_b2b", 32'(count), 32'd2);

        // STORE stalled by out_ready=0
        out_ready = 1'b0;
        send(4'd6, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd12, 32'h00512623, 10'd2, 1'b0, 1'b1, w);
        idle(3);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_out_instr", out_instr, 32'h00512623);
        chk("stall_out_addr", 32'(out_addr), 32'd2);
        chk("stall_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        idle(1);
        chk("count_after_release", 32'(count), 32'd3);
        idle(1);
        chk("count_single_handoff", 32'(count), 32'd3);

        // Error words
        chk("sticky_before_err", 32'(err_sticky), 32'd0);
        send(4'd7, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h00000193, 10'd3, 1'b1, 1'b1, w);
        idle(1);
        chk("sticky_after_err", 32'(err_sticky), 32'd1);
        send(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00000000, 10'd4, 1'b1, 1'b1, w);

        // Assorted formats and immediate boundaries
        send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 10'd5, 1'b0, 1'b1, w);
        send(4'd8, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081B3, 10'd6, 1'b0, 1'b1, w);
        send(4'd7, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3, 32'h00309093, 10'd7, 1'b0, 1'b1, w);
        send(4'd7, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32, 32'h00009093, 10'd8, 1'b1, 1'b1, w);
        send(4'd3, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00008067, 10'd9, 1'b0, 1'b1, w);
        send(4'd5, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, -32'sd4, 32'hFFC12283, 10'd10, 1'b0, 1'b1, w);
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 32'h00001097, 10'd11, 1'b1, 1'b1, w);
        send(4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E000FE3, 10'd12, 1'b0, 1'b1, w);
        send(4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163, 10'd13, 1'b1, 1'b1, w);
        send(4'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF00013, 10'd14, 1'b0, 1'b1, w);
        send(4'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h80000013, 10'd15, 1'b0, 1'b1, w);
        idle(2);
        chk("count_after_vectors", 32'(count), 32'd16);

        // clear drops a pending word
        out_ready = 1'b0;
        send(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0, 10'd0, 1'b0, 1'b0, w);
        idle(1);
        chk("pending_before_clear", 32'(out_valid), 32'd1);
        clear = 1'b1; start_addr = 10'h3F0;
        idle(1);
        clear = 1'b0;
        chk("clear_out_valid", 32'(out_valid), 32'd0);
        chk("clear_err_sticky", 32'(err_sticky), 32'd0);
        chk("clear_count", 32'(count), 32'd0);

        // Address wrap 0x3F0 .. 0x3FF -> 0x000
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 32'h00000093 | (32'(i) << 20),
                 10'(10'h3F0 + i), 1'b0, 1'b1, w);
        end
        idle(2);
        chk("count_after_wrap", 32'(count), 32'd17);

        // Asynchronous reset mid-cycle with a word pending
        out_ready = 1'b0;
        send(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0, 10'd0, 1'b0, 1'b0, w);
        chk("pending_before_rst", 32'(out_valid), 32'd1);
        chk("pending_addr_before_rst", 32'(out_addr), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_addr", 32'(out_addr), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
